// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV64I immediate generator. The opcode selects the immediate format,
// and the decoded result then passes through STAGES registers with stall and flush.
module imm_gen_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            nop,
  input  logic            stall,
  input  logic            in_valid,
  input  logic [31:0]     inst,
  output logic            out_valid,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      imm_type,
  output logic            illegal
);

  localparam logic [2:0] TYPE_NONE = 3'd0;
  localparam logic [2:0] TYPE_I    = 3'd1;
  localparam logic [2:0] TYPE_S    = 3'd2;
  localparam logic [2:0] TYPE_B    = 3'd3;
  localparam logic [2:0] TYPE_U    = 3'd4;
  localparam logic [2:0] TYPE_J    = 3'd5;

  typedef struct packed {
    logic            vld;
    logic [XLEN-1:0] imm;
    logic [2:0]      typ;
    logic            ill;
  } stage_t;

  stage_t stage_p [STAGES];

  // Every format is first built as a signed 32-bit value, then widened to XLEN
  function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] w);
    return XLEN'(w);
  endfunction

  function automatic stage_t decode(input logic v, input logic [31:0] i);
    stage_t     d;
    logic [5:0] sh;
    d  = '0;
    sh = (XLEN == 64) ? i[25:20] : {1'b0, i[24:20]};
    case (i[6:0])
      7'b0000011, 7'b1100111: begin
        d.typ = TYPE_I;
        d.imm = sext32({{20{i[31]}}, i[31:20]});
      end
      7'b0010011: begin
        // SLLI/SRLI/SRAI carry an unsigned shift amount instead of an immediate
        d.typ = TYPE_I;
        if (i[13:12] == 2'b01) d.imm = XLEN'(sh);
        else                   d.imm = sext32({{20{i[31]}}, i[31:20]});
      end
      7'b0100011: begin
        d.typ = TYPE_S;
        d.imm = sext32({{20{i[31]}}, i[31:25], i[11:7]});
      end
      7'b1100011: begin
        d.typ = TYPE_B;
        d.imm = sext32({{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0});
      end
      7'b0110111, 7'b0010111: begin
        d.typ = TYPE_U;
        d.imm = sext32({i[31:12], 12'b0});
      end
      7'b1101111: begin
        d.typ = TYPE_J;
        d.imm = sext32({{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0});
      end
      default: begin
        d.typ = TYPE_NONE;
        d.ill = 1'b1;
      end
    endcase
    if (v) d.vld = 1'b1;
    else   d = '0;
    return d;
  endfunction

  // Stage boundary: decode into stage 0, later stages are pure delay
  always_ff @(posedge clk) begin
    if (!rst_n || nop) begin
      for (int s = 0; s < STAGES; s++) stage_p[s] <= '0;
    end else if (!stall) begin
      stage_p[0] <= decode(in_valid, inst);
      for (int s = 1; s < STAGES; s++) stage_p[s] <= stage_p[s-1];
    end
  end

  assign out_valid = stage_p[STAGES-1].vld;
  assign imm       = stage_p[STAGES-1].imm;
  assign imm_type  = stage_p[STAGES-1].typ;
  assign illegal   = stage_p[STAGES-1].ill;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe. Four instances (32/1, 32/2, 32/3, 64/1) share one stimulus,
// and each step checks the instance whose configuration it targets.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n, nop, stall, in_valid;
  logic [31:0] inst;

  logic        v1, v2, v3, v64;
  logic [31:0] imm1, imm2, imm3;
  logic [63:0] imm64;
  logic [2:0]  t1, t2, t3, t64;
  logic        il1, il2, il3, il64;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .STAGES(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .nop(nop), .stall(stall), .in_valid(in_valid), .inst(inst),
    .out_valid(v1), .imm(imm1), .imm_type(t1), .illegal(il1));
  imm_gen_pipe #(.XLEN(32), .STAGES(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .nop(nop), .stall(stall), .in_valid(in_valid), .inst(inst),
    .out_valid(v2), .imm(imm2), .imm_type(t2), .illegal(il2));
  imm_gen_pipe #(.XLEN(32), .STAGES(3)) u_d3 (
    .clk(clk), .rst_n(rst_n), .nop(nop), .stall(stall), .in_valid(in_valid), .inst(inst),
    .out_valid(v3), .imm(imm3), .imm_type(t3), .illegal(il3));
  imm_gen_pipe #(.XLEN(64), .STAGES(1)) u_d64 (
    .clk(clk), .rst_n(rst_n), .nop(nop), .stall(stall), .in_valid(in_valid), .inst(inst),
    .out_valid(v64), .imm(imm64), .imm_type(t64), .illegal(il64));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Packs {valid, type, illegal, imm[31:0]} so one comparison covers a whole 32-bit output set
  function automatic logic [63:0] pk(input logic v, input logic [2:0] t, input logic il,
                                     input logic [31:0] im);
    return {27'd0, v, t, il, im};
  endfunction

  initial begin
    rst_n = 1'b0; nop = 1'b0; stall = 1'b0; in_valid = 1'b0; inst = 32'h0;
    cyc(); cyc();
    chk("reset_d1",  pk(v1, t1, il1, imm1), pk(0, 0, 0, 0));
    chk("reset_d3",  pk(v3, t3, il3, imm3), pk(0, 0, 0, 0));
    chk("reset_d64", {v64, t64, il64, imm64[58:0]}, 64'd0);
    rst_n = 1'b1;

    // Back-to-back stream through the 1-stage instance
    in_valid = 1'b1; inst = 32'hFFF00093; cyc();
    chk("addi_d1",  pk(v1, t1, il1, imm1), pk(1, 1, 0, 32'hFFFFFFFF));
    chk("addi_d64", imm64, 64'hFFFFFFFFFFFFFFFF);
    inst = 32'hFFDFF06F; cyc();
    chk("jal_d1", pk(v1, t1, il1, imm1), pk(1, 5, 0, 32'hFFFFFFFC));
    inst = 32'h123452B7; cyc();
    chk("lui_d1",     pk(v1, t1, il1, imm1), pk(1, 4, 0, 32'h12345000));
    chk("addi_lat_d3", pk(v3, t3, il3, imm3), pk(1, 1, 0, 32'hFFFFFFFF));
    inst = 32'h4030D093; cyc();
    chk("srai_d1", pk(v1, t1, il1, imm1), pk(1, 1, 0, 32'h00000003));
    inst = 32'hFE000CE3; cyc();
    chk("beq_d1", pk(v1, t1, il1, imm1), pk(1, 3, 0, 32'hFFFFFFF8));
    inst = 32'h00412083; cyc();
    chk("lw_d1", pk(v1, t1, il1, imm1), pk(1, 1, 0, 32'h00000004));
    in_valid = 1'b0; cyc();
    chk("bubble_d1", pk(v1, t1, il1, imm1), pk(0, 0, 0, 0));
    cyc(); cyc(); cyc();

    // Stall mid-flight on the 3-stage instance
    in_valid = 1'b1; inst = 32'hFE112E23; cyc();
    in_valid = 1'b0; cyc();
    stall = 1'b1; in_valid = 1'b1; inst = 32'h0000000F; cyc();
    chk("stall_ignore_d1", pk(v1, t1, il1, imm1), pk(0, 0, 0, 0));
    cyc();
    chk("stall_hold_d3", pk(v3, t3, il3, imm3), pk(0, 0, 0, 0));
    stall = 1'b0; in_valid = 1'b0; cyc();
    chk("sw_after_stall_d3", pk(v3, t3, il3, imm3), pk(1, 2, 0, 32'hFFFFFFFC));
    stall = 1'b1; cyc();
    chk("sw_stable1_d3", pk(v3, t3, il3, imm3), pk(1, 2, 0, 32'hFFFFFFFC));
    cyc();
    chk("sw_stable2_d3", pk(v3, t3, il3, imm3), pk(1, 2, 0, 32'hFFFFFFFC));
    stall = 1'b0; cyc();
    chk("sw_drained_d3", pk(v3, t3, il3, imm3), pk(0, 0, 0, 0));
    cyc(); cyc();

    // Flush with stall on the 2-stage instance, two instructions in flight
    in_valid = 1'b1; inst = 32'h123452B7; cyc();
    inst = 32'hFFF00093; cyc();
    chk("lui_d2", pk(v2, t2, il2, imm2), pk(1, 4, 0, 32'h12345000));
    nop = 1'b1; stall = 1'b1; inst = 32'hFFDFF06F; cyc();
    chk("flush1_d2", pk(v2, t2, il2, imm2), pk(0, 0, 0, 0));
    chk("flush_d3",  pk(v3, t3, il3, imm3), pk(0, 0, 0, 0));
    nop = 1'b0; stall = 1'b0; in_valid = 1'b0; cyc();
    chk("flush2_d2", pk(v2, t2, il2, imm2), pk(0, 0, 0, 0));
    in_valid = 1'b1; inst = 32'h4030D093; cyc();
    in_valid = 1'b0; cyc();
    chk("post_flush_d2", pk(v2, t2, il2, imm2), pk(1, 1, 0, 32'h00000003));

    // RV64 forms, shamt width, illegal opcodes and mid-stream reset
    in_valid = 1'b1; inst = 32'h800000B7; cyc();
    chk("lui64_imm",  imm64, 64'hFFFFFFFF80000000);
    chk("lui64_type", {61'd0, t64}, 64'd4);
    inst = 32'h03F09093; cyc();
    chk("slli64_imm", imm64, 64'h000000000000003F);
    chk("slli32_d1",  pk(v1, t1, il1, imm1), pk(1, 1, 0, 32'h0000001F));
    inst = 32'h0000000F; cyc();
    chk("fence_d1", pk(v1, t1, il1, imm1), pk(1, 0, 1, 32'h0));
    inst = 32'h00000073; cyc();
    chk("ecall_d64", {v64, t64, il64, imm64[58:0]}, {1'b1, 3'd0, 1'b1, 59'd0});
    inst = 32'hFFF00093; rst_n = 1'b0; cyc();
    chk("midreset_d1", pk(v1, t1, il1, imm1), pk(0, 0, 0, 0));
    chk("midreset_d3", pk(v3, t3, il3, imm3), pk(0, 0, 0, 0));
    rst_n = 1'b1; in_valid = 1'b0; cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined RV32I/RV64I immediate generator with valid tracking, stall and flush. Takes the full 32-bit instruction and decodes the immediate format from the opcode itself, so no external format-select strobes are needed. Sits in the decode stage beside the register file and feeds the ALU operand mux and the branch/jump target adder. Adds configurable latency, shift-amount extraction and illegal-format flagging.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
STAGES, 1, register stages from input to output; legal values 1..3.

Ports:
clk  input  1  processor main clock; all state updates on rising edge.
rst_n  input  1  synchronous active-low reset.
nop  input  1  flush; clears the whole pipeline on the next edge.
stall  input  1  hold; freezes every stage.
in_valid  input  1  inst carries a real instruction this cycle.
inst  input  32  instruction word.
out_valid  output  1  imm/imm_type/illegal are valid.
imm  output  XLEN  generated immediate, sign- or zero-extended to XLEN.
imm_type  output  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J.
illegal  output  1  valid instruction whose opcode has no immediate format handled here.

Behaviour:
- Reset: synchronous on rising clk while rst_n=0. Every stage register is cleared: out_valid=0, imm=0, imm_type=0, illegal=0. Reset has priority over nop and stall.
- Opcode decode (inst[6:0]):
  - I-type: 0000011 LOAD, 0010011 OP-IMM, 1100111 JALR, 0000111 and 1110011 are NOT decoded.
  - S-type: 0100011.
  - B-type: 1100011.
  - U-type: 0110111 LUI, 0010111 AUIPC.
  - J-type: 1101111.
  - Any other opcode: imm_type=NONE, imm=0, illegal=in_valid.
- Immediate formation (s = inst[31], sign-extended to XLEN):
  - I: inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: {inst[31:12], 12'b0}; for XLEN=64, bits 63:32 are copies of inst[31].
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
- Shift special case: OP-IMM with funct3 = 001 or 101 yields imm = shamt, zero-extended. Shamt is inst[24:20] for XLEN=32 and inst[25:20] for XLEN=64. imm_type stays I.
- Pipeline:
  - Decode is combinational into stage 1. Stages 2..STAGES are pure delay.
  - Latency is exactly STAGES cycles from the sampling edge to out_valid.
  - Input is sampled when in_valid=1 and stall=0.
  - If in_valid=0 and stall=0, a bubble enters: valid=0, data cleared to 0.
- Stall: when stall=1 and nop=0, all stages hold their contents and the input is ignored. Outputs stay stable for the duration of the stall.
- Flush: nop=1 clears every stage (valid and data) on the next edge. nop has priority over stall and over a simultaneous in_valid, so the input that cycle is dropped.
- Outputs are registered. When out_valid=0, imm, imm_type and illegal read 0.
- Back-to-back: one instruction accepted per cycle with no gaps. Ordering is preserved.

Test Plan:
- XLEN=32, STAGES=1, reset, then in_valid=1 inst=0xFFF00093 (addi x1,x0,-1) -> next cycle out_valid=1, imm=0xFFFFFFFF, imm_type=1, illegal=0.
- Back-to-back 0xFFDFF06F (jal x0,-4), 0x123452B7 (lui x5,0x12345), 0x4030D093 (srai x1,x1,3) -> on consecutive cycles imm = 0xFFFFFFFC/type 5, then 0x12345000/type 4, then 0x00000003/type 1.
- STAGES=3, inst=0xFE112E23 (sw x1,-4(x2)) with stall=1 held 2 cycles mid-flight -> out_valid rises after 3+2=5 cycles, imm=0xFFFFFFFC, imm_type=2, held stable while stall=1.
- STAGES=2, two instructions in flight, assert nop and stall together -> next cycle every stage is cleared, out_valid=0 for 2 cycles, then the next input appears normally.
- XLEN=64, inst=0x800000B7 (lui x1,0x80000) -> imm=0xFFFFFFFF80000000. inst=0x03F09093 (slli x1,x1,63) -> imm=0x000000000000003F.
- inst=0x0000000F (fence) with in_valid=1 -> illegal=1, imm_type=0, imm=0. Assert rst_n=0 mid-stream -> next edge out_valid=0 and all outputs 0.
